// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for a shared packet bus: pops one pending driver FIFO and pushes its word to the destination FIFO.
// Optional broadcast delivery is enabled by defining BUS_SCHED_BCAST_EN.
module bus_rr_scheduler #(
  parameter int         drvrs    = 4,
  parameter int         pckg_sz  = 16,
  parameter logic [7:0] BCAST_ID = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic                     err,
  output logic [7:0]               drop_cnt
);

  localparam int         PW     = $clog2(drvrs);
  localparam logic [7:0] DRVRS8 = 8'(drvrs);
  localparam logic [PW:0] DRV_W = (PW+1)'(drvrs);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_reg;
  logic [PW-1:0]     ptr_reg;

  logic [pckg_sz-1:0] words [drvrs];
  logic [PW-1:0]      gnt;
  logic               found;
  logic [PW:0]        idx;
  logic [pckg_sz-1:0] gnt_word;
  logic [7:0]         dest;
  logic [drvrs-1:0]   pop_next;
  logic [drvrs-1:0]   push_next;
  logic               drop;
  logic [PW-1:0]      ptr_next;

  generate
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_words
      assign words[gi] = D_pop[gi*pckg_sz +: pckg_sz];
    end
  endgenerate

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk the request vector starting at the pointer, wrapping past the last driver.
    for (int k = 0; k < drvrs; k++) begin
      idx = {1'b0, ptr_reg} + (PW+1)'(k);
      if (idx >= DRV_W) idx = idx - DRV_W;
      if (!found && pndng[idx[PW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[PW-1:0];
      end
    end

    gnt_word      = words[gnt];
    dest          = gnt_word[pckg_sz-1 -: 8];
    pop_next      = '0;
    pop_next[gnt] = 1'b1;
    push_next     = '0;
    drop          = 1'b1;

    if (dest < DRVRS8 && dest != 8'(gnt)) begin
      push_next[dest[PW-1:0]] = 1'b1;
      drop                    = 1'b0;
    end
`ifdef BUS_SCHED_BCAST_EN
    else if (dest == BCAST_ID) begin
      push_next = ~pop_next;
      drop      = 1'b0;
    end
`endif

    ptr_next = (gnt == PW'(drvrs-1)) ? '0 : gnt + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      pop       <= '0;
      push      <= '0;
      D_push    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pndng) begin
            state_reg <= XFER;
            ptr_reg   <= ptr_next;
            pop       <= pop_next;
            push      <= push_next;
            D_push    <= gnt_word;
            busy      <= 1'b1;
            err       <= drop;
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
        end
        XFER: begin
          // Single-cycle transfer; the FIFO sees the pop before the next arbitration.
          state_reg <= IDLE;
          pop       <= '0;
          push      <= '0;
          busy      <= 1'b0;
          err       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
